// File: rtl/ldpc_msg_ram.sv
// Simple-dual-port LDPC message RAM. Features write-first bypass, 1- or 2-cycle
// read latency, and a clear sequencer that loads INIT_VAL after reset or i_clr.
module ldpc_msg_ram #(
   parameter int              WIDTH    = 8,
   parameter int              DEPTH    = 1024,
   parameter int              ADDR_W   = 10,
   parameter int              RD_LAT   = 1,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   output logic              o_busy,
   input  logic              i_wen,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic              i_ren,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata,
   output logic              o_rvalid
);

   localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  data;
   } wr_req_t;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
   } rd_req_t;

   state_t           state, state_n;
   logic [IDX_W-1:0] ptr, ptr_n;

   wr_req_t          wr;
   rd_req_t          rd;
   logic             ready, flush, waddr_ok, raddr_ok, wr_acc, rd_acc;
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] rd_q1;
   logic [RD_LAT:1]  vld_q;
   logic [RD_LAT:0]  vld_pipe;

   logic [WIDTH-1:0] mem [DEPTH];

   // ---------------- clear sequencer ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      case (state)
         S_CLEAR: begin
            if (i_clr) begin
               ptr_n = '0;
            end else if (ptr == LAST_IDX) begin
               state_n = S_READY;
               ptr_n   = '0;
            end else begin
               ptr_n = ptr + 1'b1;
            end
         end
         S_READY: begin
            if (i_clr) begin
               state_n = S_CLEAR;
               ptr_n   = '0;
            end
         end
         default: begin
            state_n = S_CLEAR;
            ptr_n   = '0;
         end
      endcase
   end

   assign o_busy = (state == S_CLEAR);
   assign ready  = (state == S_READY);
   // A clear request in READY wins over any access presented with it
   assign flush  = ready & i_clr;

   // ---------------- request acceptance ----------------
   assign wr       = '{en: i_wen, addr: i_waddr, data: i_wdata};
   assign rd       = '{en: i_ren, addr: i_raddr};
   assign waddr_ok = {1'b0, wr.addr} < DEPTH_A;
   assign raddr_ok = {1'b0, rd.addr} < DEPTH_A;
   assign wr_acc   = ready & ~i_clr & wr.en & waddr_ok;
   assign rd_acc   = ready & ~i_clr & rd.en;

   // ---------------- storage ----------------
   always_ff @(posedge clk) begin
      if (!ready)
         mem[ptr] <= INIT_VAL;
      else if (wr_acc)
         mem[wr.addr[IDX_W-1:0]] <= wr.data;
   end

   // Write-first: a same-cycle write to the read address forwards its data
   always_comb begin
      rd_word = INIT_VAL;
      if (raddr_ok)
         rd_word = (wr_acc && (wr.addr == rd.addr)) ? wr.data : mem[rd.addr[IDX_W-1:0]];
   end

   // ---------------- read pipeline ----------------
   assign vld_pipe = {vld_q, rd_acc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vld_q <= '0;
      else if (flush)
         vld_q <= '0;
      else
         vld_q <= vld_pipe[RD_LAT-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_q1 <= '0;
      else if (rd_acc)
         rd_q1 <= rd_word;
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [WIDTH-1:0] rd_q2;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               rd_q2 <= '0;
            else if (vld_q[1] && !flush)
               rd_q2 <= rd_q1;
         end
         assign o_rdata = rd_q2;
      end else begin : g_lat1
         assign o_rdata = rd_q1;
      end
   endgenerate

   assign o_rvalid = vld_q[RD_LAT];

endmodule
